// File: rtl/trigger_sequencer_pkg.sv
// Shared types and encodings for the trigger sequencer.
package trigger_sequencer_pkg;

    localparam int CW_DEFAULT      = 32;
    localparam int ARM_ACK_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_ARMED,
        S_WAIT_TRIG,
        S_HOLD,
        S_CLEAR,
        S_GAP
    } seq_state_t;

    typedef logic [1:0] seq_status_t;

    localparam seq_status_t ST_OK      = 2'd0;
    localparam seq_status_t ST_ARM_ERR = 2'd1;
    localparam seq_status_t ST_TIMEOUT = 2'd2;
    localparam seq_status_t ST_ABORT   = 2'd3;

endpackage

// File: rtl/trigger_sequencer_down_counter.sv
// Loadable down-counter shared by the hold, gap and trigger-timeout waits.
// Load has priority over decrement; the count stops at zero.
module seq_down_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_value,
    output logic          zero
);

    logic [CW-1:0] count;

    // Count register: load on state entry, decrement while enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-shot acquisition sequencer for the counter-delayed trigger block.
// Handshake: cdt_arm and cdt_trigger_reset are single-cycle pulses; the block
// answers arm with a level on cdt_armed and reports a hit as a level on
// cdt_trigger that stays up until trigger_reset. All outputs are registered
// decodes of the state held during the previous cycle.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
#(
    parameter int ARM_ACK_CYCLES = ARM_ACK_DEFAULT,
    parameter int CW             = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_triggers,
    input  logic [CW-1:0] hold_cycles,
    input  logic [CW-1:0] rearm_gap,
    input  logic [CW-1:0] trig_timeout,
    input  logic          cdt_trigger,
    input  logic          cdt_armed,
    input  logic [CW-1:0] cdt_last_counter,
    output logic          cdt_arm,
    output logic          cdt_trigger_reset,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] trigger_count,
    output logic [CW-1:0] snapshot,
    output logic          snapshot_valid,
    output logic [1:0]    status
);

    localparam int AW = $clog2(ARM_ACK_CYCLES + 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ARM_ACK_CYCLES - 1);

    seq_state_t    state;
    logic          trig_q;
    logic          rise;
    logic          run_done;
    logic          hit_pend;
    logic [CW-1:0] snap_pend;
    logic [AW-1:0] ack_cnt;
    logic          tmo_en;
    logic          cnt_load;
    logic          cnt_en;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;

    // A wait of N cycles loads N-1; zero still yields a single-cycle wait.
    function automatic logic [CW-1:0] less_one(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - CW'(1);
    endfunction

    seq_down_counter #(.CW(CW)) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .en         (cnt_en),
        .load_value (cnt_value),
        .zero       (cnt_zero)
    );

    // Edge detect, run-end decision and wait-counter load on state entry.
    always_comb begin
        rise      = cdt_trigger & ~trig_q;
        run_done  = (status != ST_OK) ||
                    ((num_triggers != '0) && (trigger_count == num_triggers));
        cnt_en    = (state == S_WAIT_TRIG) || (state == S_HOLD) || (state == S_GAP);
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state)
            S_WAIT_ARMED: if (!abort && cdt_armed) begin
                cnt_load  = 1'b1;
                cnt_value = less_one(trig_timeout);
            end
            S_WAIT_TRIG: if (!abort && rise) begin
                cnt_load  = 1'b1;
                cnt_value = less_one(hold_cycles);
            end
            S_CLEAR: if (!abort && !run_done) begin
                cnt_load  = 1'b1;
                cnt_value = less_one(rearm_gap);
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered outputs; abort overrides the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            trig_q            <= 1'b0;
            hit_pend          <= 1'b0;
            snap_pend         <= '0;
            ack_cnt           <= '0;
            tmo_en            <= 1'b0;
            cdt_arm           <= 1'b0;
            cdt_trigger_reset <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            trigger_count     <= '0;
            snapshot          <= '0;
            snapshot_valid    <= 1'b0;
            status            <= ST_OK;
        end else begin
            trig_q            <= cdt_trigger;
            cdt_arm           <= (state == S_ARM);
            cdt_trigger_reset <= (state == S_CLEAR);
            busy              <= (state != S_IDLE);
            done              <= 1'b0;
            snapshot_valid    <= hit_pend;
            hit_pend          <= 1'b0;
            if (hit_pend) begin
                snapshot      <= snap_pend;
                trigger_count <= trigger_count + CW'(1);
            end

            case (state)
                S_IDLE: if (start) begin
                    trigger_count <= '0;
                    status        <= ST_OK;
                    state         <= S_ARM;
                end
                S_ARM: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ARMED;
                end
                S_WAIT_ARMED: begin
                    if (cdt_armed) begin
                        tmo_en <= (trig_timeout != '0);
                        state  <= S_WAIT_TRIG;
                    end else if (ack_cnt == ACK_LAST) begin
                        status <= ST_ARM_ERR;
                        state  <= S_CLEAR;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                S_WAIT_TRIG: begin
                    if (rise) begin
                        hit_pend  <= 1'b1;
                        snap_pend <= cdt_last_counter;
                        state     <= S_HOLD;
                    end else if (tmo_en && cnt_zero) begin
                        status <= ST_TIMEOUT;
                        state  <= S_CLEAR;
                    end
                end
                S_HOLD: if (cnt_zero) state <= S_CLEAR;
                S_CLEAR: begin
                    if (run_done) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: if (cnt_zero) state <= S_ARM;
                default: state <= S_IDLE;
            endcase

            if (abort && (state != S_IDLE)) begin
                status <= ST_ABORT;
                done   <= 1'b0;
                state  <= S_CLEAR;
            end
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with a behavioural trigger-block model.
module tb_trigger_sequencer;

    localparam int CW        = 32;
    localparam int ACK       = 8;
    localparam int ARMED_DLY = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_triggers = '0;
    logic [CW-1:0] hold_cycles = '0;
    logic [CW-1:0] rearm_gap = '0;
    logic [CW-1:0] trig_timeout = '0;
    logic          cdt_trigger = 1'b0;
    logic          cdt_armed = 1'b0;
    logic [CW-1:0] cdt_last_counter = '0;
    logic          cdt_arm;
    logic          cdt_trigger_reset;
    logic          busy;
    logic          done;
    logic [CW-1:0] trigger_count;
    logic [CW-1:0] snapshot;
    logic          snapshot_valid;
    logic [1:0]    status;

    // clock/reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    trigger_sequencer #(.ARM_ACK_CYCLES(ACK), .CW(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .num_triggers      (num_triggers),
        .hold_cycles       (hold_cycles),
        .rearm_gap         (rearm_gap),
        .trig_timeout      (trig_timeout),
        .cdt_trigger       (cdt_trigger),
        .cdt_armed         (cdt_armed),
        .cdt_last_counter  (cdt_last_counter),
        .cdt_arm           (cdt_arm),
        .cdt_trigger_reset (cdt_trigger_reset),
        .busy              (busy),
        .done              (done),
        .trigger_count     (trigger_count),
        .snapshot          (snapshot),
        .snapshot_valid    (snapshot_valid),
        .status            (status)
    );

    // event log (written only by the monitor/model block)
    int arm_n = 0, tr_n = 0, done_n = 0, sv_n = 0;
    int arm_cyc = 0, tr_cyc = 0, done_cyc = 0, sv_cyc = 0, trig_cyc = 0;
    logic [CW-1:0] snap_log [64];
    int dly = 0;
    int ack_n = 0;

    // stimulus side of the model (written only by the main flow)
    int req_n = 0;
    logic [CW-1:0] trig_val = '0;
    logic ack_en = 1'b1;

    // scoreboard
    logic [CW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Monitor outputs, then update the trigger-block model.
    always @(negedge clk) begin
        if (cdt_arm === 1'b1)           begin arm_n++;  arm_cyc = cyc;  end
        if (cdt_trigger_reset === 1'b1) begin tr_n++;   tr_cyc = cyc;   end
        if (done === 1'b1)              begin done_n++; done_cyc = cyc; end
        if (snapshot_valid === 1'b1)    begin
            snap_log[sv_n % 64] = snapshot;
            sv_n++;
            sv_cyc = cyc;
        end
        if (reset || cdt_trigger_reset === 1'b1) begin
            cdt_armed   = 1'b0;
            cdt_trigger = 1'b0;
            dly         = 0;
        end else begin
            if (cdt_arm === 1'b1 && ack_en) begin
                dly = ARMED_DLY;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) cdt_armed = 1'b1;
            end
            if (req_n != ack_n) begin
                cdt_last_counter = trig_val;
                cdt_trigger      = 1'b1;
                ack_n            = req_n;
                trig_cyc         = cyc;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       return arm_n;
            1:       return tr_n;
            2:       return done_n;
            default: return sv_n;
        endcase
    endfunction

    // Wait (bounded) until event counter sel exceeds prev.
    task automatic wait_event(input int sel, input int prev, input string tag);
        int w = 0;
        while (get_cnt(sel) <= prev && w < 400) begin
            @(negedge clk); #1;
            w++;
        end
        check_val({tag, "_seen"}, 64'(get_cnt(sel) > prev), 64'd1);
    endtask

    task automatic wait_armed();
        int w = 0;
        while (cdt_armed !== 1'b1 && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        check_val("armed_seen", 64'(cdt_armed), 64'd1);
    endtask

    int st_cyc = 0;
    task automatic run_start();
        repeat (3) @(posedge clk);
        #2 start = 1'b1;
        st_cyc = cyc;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic fire(input logic [CW-1:0] v);
        @(posedge clk);
        #2 trig_val = v;
        req_n++;
        exp_q.push_back(v);
    endtask

    // One shot: wait armed, trigger, check snapshot and latencies.
    task automatic shot(input logic [CW-1:0] v, input logic [CW-1:0] exp_cnt, input int gap_exp);
        int p_sv, p_tr, p_arm;
        wait_armed();
        p_sv = sv_n; p_tr = tr_n; p_arm = arm_n;
        repeat (2) @(posedge clk);
        fire(v);
        wait_event(3, p_sv, "snap");
        check_val("snapshot", snap_log[p_sv % 64], exp_q.pop_front());
        check_val("snap_lat", 64'(sv_cyc - trig_cyc), 64'd2);
        check_val("count", trigger_count, exp_cnt);
        wait_event(1, p_tr, "treset");
        check_val("treset_lat", 64'(tr_cyc - trig_cyc), 64'd3);
        if (gap_exp > 0) begin
            wait_event(0, p_arm, "rearm");
            check_val("rearm_gap", 64'(arm_cyc - tr_cyc), 64'(gap_exp));
        end
    endtask

    int a0, t0, d0, s0;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_arm", cdt_arm, 0);
        check_val("rst_treset", cdt_trigger_reset, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_count", trigger_count, 0);
        check_val("rst_snap", snapshot, 0);
        check_val("rst_sv", snapshot_valid, 0);
        check_val("rst_status", status, 0);
        @(posedge clk); #2 reset = 1'b0;

        // three-shot run, hold 0, gap 10
        num_triggers = 3; hold_cycles = 0; rearm_gap = 10; trig_timeout = 0;
        a0 = arm_n; t0 = tr_n; d0 = done_n; s0 = sv_n;
        run_start();
        wait_event(0, a0, "arm1");
        check_val("start_lat", 64'(arm_cyc - st_cyc), 64'd2);
        check_val("busy_start", busy, 1);
        shot(32'd100, 32'd1, 11);
        shot(32'd200, 32'd2, 11);
        shot(32'd300, 32'd3, 0);
        check_val("t1_done_coinc", 64'(done_cyc), 64'(tr_cyc));
        check_val("t1_busy_at_done", busy, 1);
        @(negedge clk); #1;
        check_val("t1_busy_drop", busy, 0);
        repeat (15) @(posedge clk);
        check_val("t1_arms", 64'(arm_n - a0), 64'd3);
        check_val("t1_tresets", 64'(tr_n - t0), 64'd3);
        check_val("t1_dones", 64'(done_n - d0), 64'd1);
        check_val("t1_snaps", 64'(sv_n - s0), 64'd3);
        check_val("t1_status", status, 0);
        check_val("t1_count", trigger_count, 3);

        // armed never rises: arm error
        ack_en = 1'b0; num_triggers = 1;
        a0 = arm_n; t0 = tr_n; d0 = done_n;
        run_start();
        wait_event(1, t0, "t2_treset");
        check_val("t2_err_lat", 64'(tr_cyc - arm_cyc), 64'(ACK + 1));
        check_val("t2_done_coinc", 64'(done_cyc), 64'(tr_cyc));
        check_val("t2_status", status, 1);
        check_val("t2_count", trigger_count, 0);
        ack_en = 1'b1;

        // trigger timeout of 50 with no trigger
        trig_timeout = 50;
        t0 = tr_n; s0 = sv_n;
        run_start();
        wait_event(1, t0, "t3_treset");
        check_val("t3_tmo_lat", 64'(tr_cyc - arm_cyc), 64'(ARMED_DLY + 1 + 50 + 1));
        check_val("t3_status", status, 2);
        check_val("t3_count", trigger_count, 0);
        check_val("t3_snaps", 64'(sv_n - s0), 64'd0);
        trig_timeout = 0;

        // continuous mode, five shots, abort in GAP
        num_triggers = 0;
        a0 = arm_n; t0 = tr_n; d0 = done_n;
        run_start();
        for (int i = 0; i < 5; i++) begin
            shot(32'd1000 + 32'(i * 111), 32'(i + 1), (i < 4) ? 11 : 0);
        end
        repeat (3) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        wait_event(2, d0, "t4_done");
        check_val("t4_done_coinc", 64'(done_cyc), 64'(tr_cyc));
        check_val("t4_status", status, 3);
        check_val("t4_count", trigger_count, 5);
        repeat (20) @(posedge clk);
        check_val("t4_arms", 64'(arm_n - a0), 64'd5);
        check_val("t4_tresets", 64'(tr_n - t0), 64'd6);
        check_val("t4_dones", 64'(done_n - d0), 64'd1);

        // start while busy ignored; abort coincident with trigger
        num_triggers = 3;
        a0 = arm_n; t0 = tr_n; d0 = done_n; s0 = sv_n;
        run_start();
        wait_armed();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(posedge clk);
        check_val("t5_busy_start", 64'(arm_n - a0), 64'd1);
        @(posedge clk);
        #2 trig_val = 32'd555;
        req_n++;
        exp_q.push_back(32'd555);
        abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        wait_event(3, s0, "t5_snap");
        check_val("t5_snapshot", snap_log[s0 % 64], exp_q.pop_front());
        wait_event(2, d0, "t5_done");
        check_val("t5_count", trigger_count, 1);
        check_val("t5_status", status, 3);
        check_val("t5_done_coinc", 64'(done_cyc), 64'(tr_cyc));
        repeat (15) @(posedge clk);
        check_val("t5_tresets", 64'(tr_n - t0), 64'd1);
        check_val("t5_arms", 64'(arm_n - a0), 64'd1);

        // reset during HOLD, then a fresh single-shot run
        num_triggers = 1; hold_cycles = 20;
        s0 = sv_n;
        run_start();
        wait_armed();
        fire(32'd4242);
        wait_event(3, s0, "t6_snap");
        check_val("t6_snapshot", snap_log[s0 % 64], exp_q.pop_front());
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk); #1;
        check_val("t6_arm", cdt_arm, 0);
        check_val("t6_treset", cdt_trigger_reset, 0);
        check_val("t6_busy", busy, 0);
        check_val("t6_done", done, 0);
        check_val("t6_count", trigger_count, 0);
        check_val("t6_snap", snapshot, 0);
        check_val("t6_sv", snapshot_valid, 0);
        check_val("t6_status", status, 0);
        hold_cycles = 0;
        d0 = done_n;
        run_start();
        shot(32'd77, 32'd1, 0);
        wait_event(2, d0, "t6_done2");
        check_val("t6_status2", status, 0);
        check_val("t6_count2", trigger_count, 1);
        check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

- Sequences the counter-delayed trigger block through multi-shot acquisitions: issues its `arm` and `trigger_reset` pulses and watches `armed_status` and `trigger`.
- Snapshots `last_counter` at each trigger and counts triggers; a run ends after a programmed number of shots, on a timeout, or on abort.
- Sits between the software register bank and the trigger block, replacing direct software strobing of `arm` and `trigger_reset`.

## Interface
Parameters:
- ARM_ACK_CYCLES, 8: max cycles from `arm` pulse to `armed_status` high before error.
- CW, 32: width of counters, snapshot and config words.

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- abort  in  1  one-cycle stop request; honoured in any non-IDLE state.
- num_triggers  in  CW  shots per run; 0 = continuous until abort.
- hold_cycles  in  CW  cycles to leave trigger latched after detection.
- rearm_gap  in  CW  cycles between `trigger_reset` and next `arm`.
- trig_timeout  in  CW  max cycles waiting for trigger; 0 = wait forever.
- cdt_trigger  in  1  trigger output of the trigger block.
- cdt_armed  in  1  armed_status of the trigger block.
- cdt_last_counter  in  CW  last_counter of the trigger block.
- cdt_arm  out  1  one-cycle arm pulse.
- cdt_trigger_reset  out  1  one-cycle trigger_reset pulse.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run end.
- trigger_count  out  CW  triggers seen in current/last run.
- snapshot  out  CW  `cdt_last_counter` captured at the latest trigger.
- snapshot_valid  out  1  one-cycle pulse when `snapshot` updates.
- status  out  2  end cause: 0 ok, 1 arm error, 2 trigger timeout, 3 aborted.

## Operation
- States: IDLE, ARM, WAIT_ARMED, WAIT_TRIG, HOLD, CLEAR, GAP.
- IDLE: on `start`, clear `trigger_count` and `status`, go to ARM.
- ARM: drive `cdt_arm` high for exactly one cycle, go to WAIT_ARMED.
- WAIT_ARMED: when `cdt_armed` is high, go to WAIT_TRIG. If it is still low after ARM_ACK_CYCLES cycles, set status=1 and go to CLEAR.
- WAIT_TRIG:
  - Trigger is detected on the rising edge of `cdt_trigger`, using one registered copy.
  - On detection, in the same cycle: capture `cdt_last_counter` into `snapshot`, increment `trigger_count`, go to HOLD.
  - If `trig_timeout` is nonzero and that many cycles elapse first: status=2, go to CLEAR.
- HOLD: count `hold_cycles`; 0 means leave after one cycle. Then go to CLEAR.
- CLEAR: drive `cdt_trigger_reset` for exactly one cycle.
  - If status is nonzero: pulse `done`, go to IDLE.
  - Else if `num_triggers` is nonzero and `trigger_count` equals `num_triggers`: pulse `done`, go to IDLE.
  - Else go to GAP.
- GAP: count `rearm_gap` cycles, then go to ARM.
- abort in any non-IDLE state: status=3, next state CLEAR; if already in CLEAR, stay one more cycle for the full pulse.
  - abort and start in the same cycle in IDLE: start wins, abort ignored.
  - abort and trigger in the same cycle: the trigger is still counted and snapshotted, then go to CLEAR with status=3.
- start while busy: ignored.
- Config inputs are sampled when each counter loads (at state entry); later changes do not affect a running count.
- `trigger_count` wraps modulo 2^CW in continuous mode.

## Timing
- Reset: state IDLE; all outputs 0 (`cdt_arm`, `cdt_trigger_reset`, `busy`, `done`, `trigger_count`, `snapshot`, `snapshot_valid`, `status`). Reset overrides all inputs in the same cycle.
- All outputs are registered.
- `start` sampled at edge k → `cdt_arm` and `busy` high after edge k+1.
- `cdt_trigger` rising (first high sample at edge k):
  - `snapshot`, `trigger_count` and `snapshot_valid` update after edge k+1.
  - With hold_cycles=0, `cdt_trigger_reset` is high after edge k+2.
- With rearm_gap=G, the next `cdt_arm` comes G+1 cycles after the `cdt_trigger_reset` cycle.
- `done` is coincident with the final `cdt_trigger_reset` cycle. `busy` drops the cycle after.
- Arm-ack timeout counts from the cycle after `cdt_arm`. The ARM_ACK_CYCLES-th cycle low is the error.

## Structure
- Package `trigger_sequencer_pkg`: state enum, status encodings (ST_OK, ST_ARM_ERR, ST_TIMEOUT, ST_ABORT), default CW.
- Sub-module `seq_down_counter`: loadable CW-bit down-counter with `load`, `en` and `zero` outputs. Shared by hold, gap and timeout timing, instantiated once; these waits are mutually exclusive by state.
- FSM plus output registers live in `trigger_sequencer`.

## Test plan
- num_triggers=3, hold=0, gap=10; `cdt_armed` follows arm after 2 cycles; triggers at three distinct counter values 100, 200, 300 → 3 arm pulses, 3 snapshots 100/200/300, trigger_count=3, done once, status=0.
- `cdt_armed` never rises → `cdt_trigger_reset` at ARM_ACK_CYCLES+1 cycles after arm, done, status=1.
- trig_timeout=50, no trigger → `cdt_trigger_reset` 50 cycles into WAIT_TRIG, status=2, trigger_count=0.
- num_triggers=0 with 5 triggers, then abort in GAP → trigger_count=5, one `cdt_trigger_reset`, done, status=3, no further arm.
- abort coincident with trigger edge → snapshot taken, trigger_count=1, status=3; start while busy → no effect.
- reset asserted during HOLD → all outputs 0 next cycle, IDLE; a fresh start then runs normally.
